dc_motor_pwm_bank: RTL

Multi-channel, parametrised DC motor PWM generator. Each channel drives one phase/enable-style H-bridge driver through a 2-bit current-level code (`out_I1`/`out_I0`) plus a direction line (`out_phase`). It adds several behaviours:
- double-buffered duty/period that commit only at period boundaries;
- programmable current level;
- dead-time insertion on direction reversal;
- an immediate coast override.

It sits between the register/command interface and the motor driver pins.

---
 rtl/dc_motor_pkg.sv | 15 +
 rtl/dc_motor_pwm_channel.sv | 155 +++++++++++++++
 rtl/dc_motor_pwm_bank.sv | 64 ++++++
 3 files changed

// File: rtl/dc_motor_pkg.sv
// Shared types and constants for the DC motor PWM bank.
//   motor_state_t : per-channel bridge state (COAST / RUN / DEAD)
//   ILIM_OFF/FULL : current-level codes driven on {I1,I0}
package dc_motor_pkg;

  typedef enum logic [1:0] {
    ST_COAST = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2
  } motor_state_t;

  localparam logic [1:0] ILIM_OFF  = 2'b00;
  localparam logic [1:0] ILIM_FULL = 2'b11;

endpackage

// File: rtl/dc_motor_pwm_channel.sv
// One motor channel: staged/active config, PWM counter, COAST/RUN/DEAD FSM
// and registered driver pins.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// COAST    | bridge off, counter held at 0, config commits every cycle
// RUN      | PWM running; config commits at the last count of a period
// DEAD     | bridge off for max(deadtime,1) cycles before phase flips
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   we               write strobe for this channel's staged config
//   cfg_duty/period  staged duty and period (period 0 disables)
//   cfg_dir/ilim     staged direction and on-time current level
//   deadtime         dead-time length, sampled on entry to DEAD
//   coast            immediate coast request (level)
//   pin_i0/i1/phase  registered driver pins
//   period_start     high in the cycle the counter restarts at 0 in RUN
//   reversing        registered DEAD indicator, aligned with the pins
module dc_motor_pwm_channel
  import dc_motor_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_dir,
  input  logic [1:0]       cfg_ilim,
  input  logic [DT_W-1:0]  deadtime,
  input  logic             coast,
  output logic             pin_i0,
  output logic             pin_i1,
  output logic             pin_phase,
  output logic             period_start,
  output logic             reversing
);

  motor_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] stg_duty, stg_period, act_duty, act_period;
  logic             stg_dir, act_dir, phase;
  logic [1:0]       stg_ilim, act_ilim;
  logic [DT_W-1:0]  dt_cnt;

  // Staged view including a write landing this cycle, so a write that
  // coincides with a commit is the value that gets committed.
  logic [CNT_W-1:0] new_duty, new_period;
  logic             new_dir;
  logic [1:0]       new_ilim;

  logic             at_end, commit, dt_done, pwm_on;
  logic [CNT_W-1:0] eff_period;
  logic             eff_dir;
  logic [1:0]       ilim_nxt;

  always_comb begin
    new_duty   = we ? cfg_duty   : stg_duty;
    new_period = we ? cfg_period : stg_period;
    new_dir    = we ? cfg_dir    : stg_dir;
    new_ilim   = we ? cfg_ilim   : stg_ilim;
  end

  assign at_end     = (cnt == act_period - CNT_W'(1));
  assign commit     = (state == ST_COAST) || ((state == ST_RUN) && at_end);
  assign eff_period = commit ? new_period : act_period;
  assign eff_dir    = commit ? new_dir    : act_dir;
  // Exit DEAD at 1 (not 0) so deadtime N gives N cycles; 0 still gives one.
  assign dt_done    = (dt_cnt <= DT_W'(1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (coast) begin
      state_nxt = ST_COAST;
    end else begin
      unique case (state)
        ST_COAST: begin
          if (eff_period != '0)
            state_nxt = (eff_dir != phase) ? ST_DEAD : ST_RUN;
        end
        ST_RUN: begin
          if (commit) begin
            if (eff_period == '0)      state_nxt = ST_COAST;
            else if (eff_dir != phase) state_nxt = ST_DEAD;
          end
        end
        ST_DEAD: begin
          if (dt_done) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_COAST;
      endcase
    end
  end

  // Output / datapath next values. The on-decision uses the pre-commit
  // duty, so the period that is ending finishes with its own settings.
  always_comb begin
    cnt_nxt = '0;
    if ((state == ST_RUN) && (state_nxt == ST_RUN) && !at_end)
      cnt_nxt = cnt + CNT_W'(1);
    pwm_on   = (state == ST_RUN) && !coast && (cnt < act_duty);
    ilim_nxt = pwm_on ? act_ilim : ILIM_OFF;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_COAST;
      cnt          <= '0;
      stg_duty     <= '0;
      stg_period   <= '0;
      stg_dir      <= 1'b0;
      stg_ilim     <= ILIM_OFF;
      act_duty     <= '0;
      act_period   <= '0;
      act_dir      <= 1'b0;
      act_ilim     <= ILIM_OFF;
      phase        <= 1'b0;
      dt_cnt       <= '0;
      pin_i0       <= 1'b0;
      pin_i1       <= 1'b0;
      pin_phase    <= 1'b0;
      period_start <= 1'b0;
      reversing    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      stg_duty   <= new_duty;
      stg_period <= new_period;
      stg_dir    <= new_dir;
      stg_ilim   <= new_ilim;
      if (commit) begin
        act_duty   <= new_duty;
        act_period <= new_period;
        act_dir    <= new_dir;
        act_ilim   <= new_ilim;
      end
      if ((state_nxt == ST_DEAD) && (state != ST_DEAD))
        dt_cnt <= deadtime;
      else if ((state == ST_DEAD) && !dt_done)
        dt_cnt <= dt_cnt - DT_W'(1);
      if ((state == ST_DEAD) && (state_nxt == ST_RUN))
        phase <= act_dir;
      {pin_i1, pin_i0} <= ilim_nxt;
      pin_phase        <= phase;
      period_start     <= (state_nxt == ST_RUN) && (cnt_nxt == '0);
      reversing        <= (state == ST_DEAD);
    end
  end

endmodule

// File: rtl/dc_motor_pwm_bank.sv
// Multi-channel DC motor PWM generator: decodes configuration writes to
// one channel and instantiates CHANNELS independent channel engines.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/cfg_ch         config write strobe and target channel
//   cfg_duty/period/dir/ilim  staged config values for the write
//   deadtime              global dead-time length
//   coast                 per-channel immediate coast
//   out_I0/out_I1/out_phase   per-channel driver pins
//   period_start          per-channel period restart pulse
//   reversing             per-channel dead-time indicator
module dc_motor_pwm_bank
  import dc_motor_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  CNT_W    = 16,
  parameter int  DT_W     = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_duty,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_dir,
  input  logic [1:0]          cfg_ilim,
  input  logic [DT_W-1:0]     deadtime,
  input  logic [CHANNELS-1:0] coast,
  output logic [CHANNELS-1:0] out_I0,
  output logic [CHANNELS-1:0] out_I1,
  output logic [CHANNELS-1:0] out_phase,
  output logic [CHANNELS-1:0] period_start,
  output logic [CHANNELS-1:0] reversing
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic ch_we;
    // Channel numbers past CHANNELS-1 match no instance and are dropped.
    assign ch_we = cfg_we && (cfg_ch == CH_W'(g));

    dc_motor_pwm_channel #(
      .CNT_W (CNT_W),
      .DT_W  (DT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .we           (ch_we),
      .cfg_duty     (cfg_duty),
      .cfg_period   (cfg_period),
      .cfg_dir      (cfg_dir),
      .cfg_ilim     (cfg_ilim),
      .deadtime     (deadtime),
      .coast        (coast[g]),
      .pin_i0       (out_I0[g]),
      .pin_i1       (out_I1[g]),
      .pin_phase    (out_phase[g]),
      .period_start (period_start[g]),
      .reversing    (reversing[g])
    );
  end

endmodule
